// File: rtl/iobuf_seq_pkg.sv
// Shared definitions for the pad-buffer bus sequencer: state encoding,
// pad release level and counter sizing helpers.
package iobuf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_STROBE = 3'd4,
    ST_TURN     = 3'd5
  } state_t;

  // IOBUF T level that releases the pad to high-Z.
  localparam logic PAD_RELEASE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/iobuf_bus_sequencer.sv
// Half-duplex IOBUF bus sequencer: accepts one write/read when idle, busy for the whole
// transfer (write S+ST+H+T, read SA+T cycles); requests while busy are dropped, not queued.
module iobuf_bus_sequencer
  import iobuf_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1,
  parameter int SAMPLE_CYC = 3,
  parameter int TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] pad_t,
  output logic [DATA_W-1:0] pad_i,
  input  logic [DATA_W-1:0] pad_o,
  output logic              strobe_n
);

  localparam int MAX_P = max_int(max_int(max_int(SETUP_CYC, STROBE_CYC),
                                         max_int(HOLD_CYC, SAMPLE_CYC)), TURN_CYC);
  localparam int CNT_W = cnt_width(MAX_P);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_pad_rel;
  logic [DATA_W-1:0]   r_pad_i;
  logic                r_strobe_n;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_accept_wr;
  logic                w_sample;
  logic                w_drive_nxt;
  logic                w_strobe_nxt;
  logic                w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept_wr = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Write has priority; a simultaneous read request is simply lost.
        if (wr_req) begin
          w_state_nxt = ST_W_SETUP;
          w_cnt_nxt   = SETUP_LD;
          w_accept_wr = 1'b1;
        end else if (rd_req) begin
          w_state_nxt = ST_R_STROBE;
          w_cnt_nxt   = SAMPLE_LD;
        end
      end
      ST_W_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_W_STROBE;
          w_cnt_nxt   = STROBE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_W_STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_W_HOLD;
          w_cnt_nxt   = HOLD_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_W_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_TURN;
          w_cnt_nxt   = TURN_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_R_STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_TURN;
          w_cnt_nxt   = TURN_LD;
          w_sample    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_TURN: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  assign w_drive_nxt  = (w_state_nxt == ST_W_SETUP) || (w_state_nxt == ST_W_STROBE) ||
                        (w_state_nxt == ST_W_HOLD);
  assign w_strobe_nxt = (w_state_nxt == ST_W_STROBE) || (w_state_nxt == ST_R_STROBE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_pad_rel  <= PAD_RELEASE;
      r_pad_i    <= '0;
      r_strobe_n <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_pad_rel  <= w_drive_nxt ? ~PAD_RELEASE : PAD_RELEASE;
      r_strobe_n <= ~w_strobe_nxt;
      r_rd_valid <= w_sample;
      if (w_sample) begin
        r_rd_data <= pad_o;
      end
      if (w_accept_wr) begin
        r_pad_i <= wr_data;
      end
    end
  end

  assign busy     = r_busy;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign pad_t    = {DATA_W{r_pad_rel}};
  assign pad_i    = r_pad_i;
  assign strobe_n = r_strobe_n;

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// Bench for iobuf_bus_sequencer: transfer-timeline model compared every cycle,
// plus directed literal checks at the key cycles of each transfer.
module tb_iobuf_bus_sequencer;

  localparam int DW  = 8;
  localparam int S   = 2;
  localparam int ST  = 1;
  localparam int H   = 1;
  localparam int SA  = 3;
  localparam int T   = 1;
  localparam int W_LEN = S + ST + H + T;
  localparam int R_LEN = SA + T;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] pad_o = '0;
  logic          busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] pad_t;
  logic [DW-1:0] pad_i;
  logic          strobe_n;

  int n_chk  = 0;
  int n_fail = 0;

  iobuf_bus_sequencer #(
    .DATA_W(DW), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H),
    .SAMPLE_CYC(SA), .TURN_CYC(T)
  ) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .wr_data(wr_data),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .pad_t(pad_t),
    .pad_i(pad_i), .pad_o(pad_o), .strobe_n(strobe_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is a timeline indexed by m_t = cycles since accept.
  bit          chk_en = 1'b0;
  bit          m_act  = 1'b0;
  bit          m_wr   = 1'b0;
  int          m_t    = 0;
  logic [DW-1:0] m_pad_i = '0;
  logic [DW-1:0] m_rd    = '0;

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (reset) begin
      m_act = 1'b0; m_t = 0; m_pad_i = '0; m_rd = '0;
    end else if (m_act) begin
      m_t++;
      if (!m_wr && m_t == SA + 1) m_rd = pad_o;
      if (m_t > (m_wr ? W_LEN : R_LEN)) m_act = 1'b0;
    end else if (wr_req) begin
      m_act = 1'b1; m_wr = 1'b1; m_t = 1; m_pad_i = wr_data;
    end else if (rd_req) begin
      m_act = 1'b1; m_wr = 1'b0; m_t = 1;
    end
  end

  logic e_busy, e_drive, e_strobe_n, e_valid;
  assign e_busy     = m_act;
  assign e_drive    = m_act && m_wr && (m_t <= S + ST + H);
  assign e_strobe_n = !(m_act && (m_wr ? (m_t > S && m_t <= S + ST) : (m_t <= SA)));
  assign e_valid    = m_act && !m_wr && (m_t == SA + 1);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy",     busy,     e_busy);
      chk("m_pad_t",    pad_t,    e_drive ? 8'h00 : 8'hFF);
      chk("m_pad_i",    pad_i,    m_pad_i);
      chk("m_strobe_n", strobe_n, e_strobe_n);
      chk("m_rd_valid", rd_valid, e_valid);
      chk("m_rd_data",  rd_data,  m_rd);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int strobes;
  int valids;

  initial begin
    // Reset for 3 cycles
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_strobe_n", strobe_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);

    // Write 0xA5, accept in cycle 0
    wr_req = 1'b1; wr_data = 8'hA5;
    cyc(1); wr_req = 1'b0; wr_data = 8'h00;
    chk("w_c1_pad_t", pad_t, 8'h00);
    chk("w_c1_pad_i", pad_i, 8'hA5);
    chk("w_c1_strobe", strobe_n, 1'b1);
    chk("w_c1_busy", busy, 1'b1);
    cyc(1);
    chk("w_c2_strobe", strobe_n, 1'b1);
    cyc(1);
    chk("w_c3_strobe", strobe_n, 1'b0);
    chk("w_c3_model_strobe", e_strobe_n, 1'b0);
    chk("w_c3_pad_t", pad_t, 8'h00);
    cyc(1);
    chk("w_c4_strobe", strobe_n, 1'b1);
    chk("w_c4_pad_i", pad_i, 8'hA5);
    chk("w_c4_pad_t", pad_t, 8'h00);
    cyc(1);
    chk("w_c5_pad_t", pad_t, 8'hFF);
    chk("w_c5_busy", busy, 1'b1);
    cyc(1);
    chk("w_c6_busy", busy, 1'b0);
    chk("w_c6_model_busy", e_busy, 1'b0);

    // Read with pad_o=0x3C, switched to 0x99 after the capture edge
    pad_o = 8'h3C; rd_req = 1'b1;
    cyc(1); rd_req = 1'b0;
    chk("r_c1_strobe", strobe_n, 1'b0);
    chk("r_c1_pad_t", pad_t, 8'hFF);
    cyc(2);
    chk("r_c3_strobe", strobe_n, 1'b0);
    chk("r_c3_valid", rd_valid, 1'b0);
    cyc(1);
    pad_o = 8'h99;
    chk("r_c4_valid", rd_valid, 1'b1);
    chk("r_c4_data", rd_data, 8'h3C);
    chk("r_c4_strobe", strobe_n, 1'b1);
    chk("r_c4_model_valid", e_valid, 1'b1);
    cyc(1);
    chk("r_c5_valid", rd_valid, 1'b0);
    chk("r_c5_busy", busy, 1'b0);
    chk("r_c5_data", rd_data, 8'h3C);

    // Simultaneous write and read: write wins
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h11;
    cyc(1); wr_req = 1'b0; rd_req = 1'b0;
    strobes = 0; valids = 0;
    for (int i = 0; i < 9; i++) begin
      if (strobe_n == 1'b0) strobes++;
      if (rd_valid) valids++;
      if (i == 0) chk("both_pad_i", pad_i, 8'h11);
      cyc(1);
    end
    chk("both_strobe_cnt", strobes, 1);
    chk("both_valid_cnt", valids, 0);

    // Read pulse during a write is ignored; back-to-back write in first idle cycle
    wr_req = 1'b1; wr_data = 8'h5A;
    cyc(1); wr_req = 1'b0;
    cyc(1); rd_req = 1'b1;
    cyc(1); rd_req = 1'b0;
    cyc(3);
    chk("b2b_c6_busy", busy, 1'b0);
    wr_req = 1'b1; wr_data = 8'hC3;
    cyc(1); wr_req = 1'b0;
    chk("b2b_c7_pad_i", pad_i, 8'hC3);
    chk("b2b_c7_pad_t", pad_t, 8'h00);
    chk("b2b_c7_strobe", strobe_n, 1'b1);
    chk("b2b_c7_busy", busy, 1'b1);
    cyc(2);
    chk("b2b_c9_strobe", strobe_n, 1'b0);
    cyc(4);
    chk("b2b_idle_valid", rd_valid, 1'b0);
    chk("b2b_idle_busy", busy, 1'b0);

    // Reset during W_STROBE, then a normal read
    wr_req = 1'b1; wr_data = 8'h77;
    cyc(1); wr_req = 1'b0;
    cyc(2);
    chk("ab_c3_strobe", strobe_n, 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("ab_pad_t", pad_t, 8'hFF);
    chk("ab_strobe", strobe_n, 1'b1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_pad_i", pad_i, 8'h00);
    chk("ab_valid", rd_valid, 1'b0);
    cyc(1);
    pad_o = 8'hE7; rd_req = 1'b1;
    cyc(1); rd_req = 1'b0;
    cyc(3);
    chk("ab_rd_valid", rd_valid, 1'b1);
    chk("ab_rd_data", rd_data, 8'hE7);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
